// File: rtl/mpmc9_ch_arbiter.sv
// mpmc9 channel arbiter: picks one of eight requesters for the single memory
// port. High-priority class (PRIO_MASK) and age-boosted starved channels are
// served first; ties are broken round-robin from rr_ptr. The grant is held from
// selection until the sequencer reports completion.
module mpmc9_ch_arbiter #(
  parameter int               NCH        = 8,
  parameter logic [7:0]       PRIO_MASK  = 8'h01,
  parameter int               AGE_W      = 4,
  parameter logic [AGE_W-1:0] STARVE_LIM = 4'd12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] ch_en,
  input  logic       acc,
  input  logic       done,
  output logic       gnt_vld,
  output logic [7:0] gnt,
  output logic [3:0] ch,
  output logic       busy
);

  localparam logic [1:0] A_IDLE  = 2'd0;
  localparam logic [1:0] A_GRANT = 2'd1;
  localparam logic [1:0] A_BUSY  = 2'd2;

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [2:0]       rr_ptr_r;
  logic [AGE_W-1:0] age_r [NCH];

  logic [7:0] elig_s;
  logic [7:0] starved_s;
  logic [7:0] hi_s;
  logic [7:0] set_s;
  logic       win_found_s;
  logic [2:0] win_idx_s;
  logic       decide_s;

  // Eligible set, starvation flags and the candidate class for this cycle.
  always_comb begin
    elig_s    = req & ch_en;
    starved_s = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      starved_s[i] = (age_r[i] >= STARVE_LIM);
    end
    hi_s  = elig_s & (PRIO_MASK | starved_s);
    set_s = (hi_s != 8'h00) ? hi_s : elig_s;
  end

  // Rotating first-set scan of the candidate set starting at rr_ptr.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    for (int k = 0; k < NCH; k++) begin
      if (!win_found_s && set_s[rr_ptr_r + 3'(k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_ptr_r + 3'(k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // A winner decision is made only in A_IDLE with at least one eligible channel.
  always_comb begin
    if (state_r == A_IDLE) begin
      decide_s = win_found_s;
    end else begin
      decide_s = 1'b0;
    end
  end

  // Grant FSM: select, wait for accept, hold until the transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= A_IDLE;
      ch       <= 4'hF;
      gnt      <= 8'h00;
      gnt_vld  <= 1'b0;
      busy     <= 1'b0;
      rr_ptr_r <= 3'd0;
    end else begin
      case (state_r)
        A_IDLE: begin
          if (decide_s) begin
            ch      <= {1'b0, win_idx_s};
            gnt     <= 8'h01 << win_idx_s;
            gnt_vld <= 1'b1;
            state_r <= A_GRANT;
          end else begin
            ch      <= 4'hF;
            gnt     <= 8'h00;
          end
        end
        A_GRANT: begin
          // A done arriving together with acc belongs to no accepted
          // transaction yet, so it is dropped here.
          if (acc) begin
            gnt_vld <= 1'b0;
            busy    <= 1'b1;
            state_r <= A_BUSY;
          end
        end
        A_BUSY: begin
          if (done) begin
            busy     <= 1'b0;
            gnt      <= 8'h00;
            ch       <= 4'hF;
            rr_ptr_r <= ch[2:0] + 3'd1;
            state_r  <= A_IDLE;
          end
        end
        default: begin
          state_r <= A_IDLE;
          ch      <= 4'hF;
          gnt     <= 8'h00;
          gnt_vld <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel ages: losers that were eligible age (saturating), winner clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        age_r[i] <= {AGE_W{1'b0}};
      end
    end else if (decide_s) begin
      for (int i = 0; i < NCH; i++) begin
        if (3'(i) == win_idx_s) begin
          age_r[i] <= {AGE_W{1'b0}};
        end else if (elig_s[i] && (age_r[i] != AGE_MAX)) begin
          age_r[i] <= age_r[i] + AGE_ONE;
        end
      end
    end
  end

endmodule
